// File: rtl/tlda_param_raster_if.sv
// rtl/tlda_param_raster_if.sv - command, status and pixel-write bundle of the raster engine
//
// Purpose : groups the shape command inputs, the status outputs and the
//           Draw/Write_Finish pixel handshake into one bundle.
// Signals : Go, Mode, X0, X1, Y0, Y1, Thickness, Color   shape command
//           Busy, Done                                   status
//           Draw, Pixel_Address, Pixel_Color             pixel write request
//           Write_Finish                                 pixel accepted by the buffer master
// Modports: master - drives the command and Write_Finish (sequencer / buffer side)
//           slave  - the raster engine itself
interface tlda_param_raster_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int T_W     = 9,
    parameter int COLOR_W = 16,
    parameter int ADDR_W  = 32
);
    logic               Go;
    logic               Mode;
    logic [X_W-1:0]     X0;
    logic [X_W-1:0]     X1;
    logic [Y_W-1:0]     Y0;
    logic [Y_W-1:0]     Y1;
    logic [T_W-1:0]     Thickness;
    logic [COLOR_W-1:0] Color;
    logic               Busy;
    logic               Done;
    logic               Draw;
    logic               Write_Finish;
    logic [ADDR_W-1:0]  Pixel_Address;
    logic [COLOR_W-1:0] Pixel_Color;

    modport master (
        output Go, Mode, X0, X1, Y0, Y1, Thickness, Color, Write_Finish,
        input  Busy, Done, Draw, Pixel_Address, Pixel_Color
    );

    modport slave (
        input  Go, Mode, X0, X1, Y0, Y1, Thickness, Color, Write_Finish,
        output Busy, Done, Draw, Pixel_Address, Pixel_Color
    );
endinterface

// File: rtl/tlda_param_raster.sv
// rtl/tlda_param_raster.sv - thick Bresenham line / filled rectangle rasteriser with clipping
//
// Purpose : turns one latched shape command into a sequence of pixel write
//           requests; off-screen pixels are dropped without a request.
// Ports   : clk     clock, rising edge
//           resetn  asynchronous active-low reset
//           bus     tlda_param_raster_if.slave (command, status, pixel handshake)
module tlda_param_raster #(
    parameter int                X_W          = 9,
    parameter int                Y_W          = 8,
    parameter int                T_W          = 9,
    parameter int                COLOR_W      = 16,
    parameter int                ADDR_W       = 32,
    parameter int                SCREEN_W     = 320,
    parameter int                SCREEN_H     = 240,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h0800_0000,
    parameter int                STRIDE_BYTES = 1024,
    parameter int                PIX_BYTES    = 2
) (
    input  logic               clk,
    input  logic               resetn,
    tlda_param_raster_if.slave bus
);
    // Wide enough for either coordinate plus a full thickness offset, signed.
    localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + T_W + 1;

    localparam logic signed [CW-1:0] ONE  = CW'(1);
    localparam logic signed [CW-1:0] MONE = -ONE;
    localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EVAL, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t             state_q;
    logic               setup_ph_q;
    logic               mode_q;
    logic [X_W-1:0]     x0_q, x1_q;
    logic [Y_W-1:0]     y0_q, y1_q;
    logic [T_W-1:0]     thick_q;
    logic [COLOR_W-1:0] color_q;

    logic signed [CW-1:0] dx_q, dy_q, sx_q, sy_q;
    logic                 steep_q;
    // maj/mnr: current major and minor coordinate; the drawn pixel sits at
    // mnr + off_base + k along the minor axis.
    logic signed [CW-1:0] maj_q, mnr_q, sgn_maj_q, sgn_mnr_q;
    logic signed [CW-1:0] major_q, minor_q, err_q, off_base_q;
    logic [CW-1:0]        k_q, k_last_q, j_q, j_last_q;

    logic               busy_q, done_q, draw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] pcolor_q;

    logic signed [CW-1:0] x0_s, x1_s, y0_s, y1_s;
    assign x0_s = $signed(CW'(x0_q));
    assign x1_s = $signed(CW'(x1_q));
    assign y0_s = $signed(CW'(y0_q));
    assign y1_s = $signed(CW'(y1_q));

    logic [T_W-1:0]       t_eff;
    logic signed [CW-1:0] tm1;
    assign t_eff = (thick_q == '0) ? T_W'(1) : thick_q;
    assign tm1   = $signed(CW'(t_eff)) - ONE;

    logic signed [CW-1:0] xmin, ymin;
    assign xmin = (x1_s < x0_s) ? x1_s : x0_s;
    assign ymin = (y1_s < y0_s) ? y1_s : y0_s;

    // Candidate pixel for the current (major point, minor offset) pair.
    logic signed [CW-1:0] mn_d, cand_x, cand_y;
    logic                 visible;
    logic [ADDR_W-1:0]    addr_d;
    assign mn_d    = mnr_q + off_base_q + $signed(k_q);
    assign cand_x  = steep_q ? mn_d  : maj_q;
    assign cand_y  = steep_q ? maj_q : mn_d;
    assign visible = !cand_x[CW-1] && (cand_x < SW_S) && !cand_y[CW-1] && (cand_y < SH_S);
    assign addr_d  = BASE_ADDR
                   + ADDR_W'($unsigned(cand_y)) * ADDR_W'(STRIDE_BYTES)
                   + ADDR_W'($unsigned(cand_x)) * ADDR_W'(PIX_BYTES);

    logic signed [CW-1:0] err_sub;
    assign err_sub = err_q - minor_q;

    // Advance happens after a clipped candidate or after an accepted write.
    logic   adv_now;
    state_t adv_state;
    always_comb begin
        adv_now   = (state_q == S_EVAL && !visible) || (state_q == S_WAIT && bus.Write_Finish);
        adv_state = S_DONE;
        if (k_q != k_last_q) begin
            adv_state = S_EVAL;
        end else if (j_q != j_last_q) begin
            adv_state = S_NEXT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            setup_ph_q <= 1'b0;
            mode_q     <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            thick_q    <= '0;
            color_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            steep_q    <= 1'b0;
            maj_q      <= '0;
            mnr_q      <= '0;
            sgn_maj_q  <= '0;
            sgn_mnr_q  <= '0;
            major_q    <= '0;
            minor_q    <= '0;
            err_q      <= '0;
            off_base_q <= '0;
            k_q        <= '0;
            k_last_q   <= '0;
            j_q        <= '0;
            j_last_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            draw_q     <= 1'b0;
            addr_q     <= '0;
            pcolor_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Go) begin
                        mode_q     <= bus.Mode;
                        x0_q       <= bus.X0;
                        x1_q       <= bus.X1;
                        y0_q       <= bus.Y0;
                        y1_q       <= bus.Y1;
                        thick_q    <= bus.Thickness;
                        color_q    <= bus.Color;
                        busy_q     <= 1'b1;
                        setup_ph_q <= 1'b0;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (!setup_ph_q) begin
                        dx_q       <= (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
                        dy_q       <= (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);
                        sx_q       <= (x1_s >= x0_s) ? ONE : MONE;
                        sy_q       <= (y1_s >= y0_s) ? ONE : MONE;
                        setup_ph_q <= 1'b1;
                    end else begin
                        k_q     <= '0;
                        j_q     <= '0;
                        state_q <= S_EVAL;
                        if (mode_q) begin
                            // Rectangle: rows are major points, columns the offsets;
                            // zero minor step keeps the column origin fixed.
                            steep_q    <= 1'b1;
                            maj_q      <= ymin;
                            mnr_q      <= xmin;
                            sgn_maj_q  <= ONE;
                            sgn_mnr_q  <= '0;
                            major_q    <= '0;
                            minor_q    <= '0;
                            err_q      <= '0;
                            off_base_q <= '0;
                            k_last_q   <= $unsigned(dx_q);
                            j_last_q   <= $unsigned(dy_q);
                        end else begin
                            k_last_q   <= $unsigned(tm1);
                            off_base_q <= -(tm1 >>> 1);
                            if (dy_q > dx_q) begin
                                steep_q   <= 1'b1;
                                maj_q     <= y0_s;
                                mnr_q     <= x0_s;
                                sgn_maj_q <= sy_q;
                                sgn_mnr_q <= sx_q;
                                major_q   <= dy_q;
                                minor_q   <= dx_q;
                                err_q     <= dy_q >>> 1;
                                j_last_q  <= $unsigned(dy_q);
                            end else begin
                                steep_q   <= 1'b0;
                                maj_q     <= x0_s;
                                mnr_q     <= y0_s;
                                sgn_maj_q <= sx_q;
                                sgn_mnr_q <= sy_q;
                                major_q   <= dx_q;
                                minor_q   <= dy_q;
                                err_q     <= dx_q >>> 1;
                                j_last_q  <= $unsigned(dx_q);
                            end
                        end
                    end
                end
                S_EVAL: begin
                    if (visible) begin
                        draw_q   <= 1'b1;
                        addr_q   <= addr_d;
                        pcolor_q <= color_q;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.Write_Finish) begin
                        draw_q <= 1'b0;
                    end
                end
                S_NEXT: begin
                    maj_q   <= maj_q + sgn_maj_q;
                    j_q     <= j_q + 1'b1;
                    k_q     <= '0;
                    state_q <= S_EVAL;
                    if (err_sub < 0) begin
                        mnr_q <= mnr_q + sgn_mnr_q;
                        err_q <= err_sub + major_q;
                    end else begin
                        err_q <= err_sub;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (adv_now) begin
                state_q <= adv_state;
                if (k_q != k_last_q) begin
                    k_q <= k_q + 1'b1;
                end
                if (adv_state == S_DONE) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.Draw          = draw_q;
    assign bus.Pixel_Address = addr_q;
    assign bus.Pixel_Color   = pcolor_q;
endmodule

// File: tb/tb_tlda_param_raster.sv
// tb/tb_tlda_param_raster.sv - scoreboard bench for the thick-line / rectangle rasteriser
module tb_tlda_param_raster;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tlda_param_raster_if bus ();

    tlda_param_raster dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int   total = 0;
    int   bad = 0;
    int   pix_cnt = 0;
    int   done_cnt = 0;
    bit   auto_ack = 1'b0;
    logic [47:0] exp_q[$];

    function automatic logic [47:0] pix(input int x, input int y, input logic [15:0] c);
        logic [31:0] a;
        a = BASE + 32'(y) * 32'd1024 + 32'(x) * 32'd2;
        return {c, a};
    endfunction

    // Buffer-master model: randomly accepts a pending pixel.
    initial begin
        bus.Write_Finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack && bus.Draw) bus.Write_Finish = ($urandom_range(0, 1) == 1);
            else bus.Write_Finish = 1'b0;
        end
    end

    // Scoreboard: every accepted pixel is compared with the next expected one.
    always @(negedge clk) begin
        logic [47:0] e;
        if (resetn && bus.Done) done_cnt++;
        if (resetn && bus.Draw && bus.Write_Finish) begin
            pix_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pixel_extra got addr=%h color=%h want none", bus.Pixel_Address, bus.Pixel_Color);
            end else begin
                e = exp_q.pop_front();
                if ({bus.Pixel_Color, bus.Pixel_Address} !== e) begin
                    bad++;
                    $display("FAIL pixel got addr=%h color=%h want addr=%h color=%h",
                             bus.Pixel_Address, bus.Pixel_Color, e[31:0], e[47:32]);
                end
            end
        end
    end

    task automatic start(input bit m, input int x0, input int y0, input int x1, input int y1,
                         input int t, input logic [15:0] c);
        @(posedge clk);
        #1;
        bus.Mode = m;
        bus.X0 = 9'(x0);
        bus.Y0 = 8'(y0);
        bus.X1 = 9'(x1);
        bus.Y1 = 8'(y1);
        bus.Thickness = 9'(t);
        bus.Color = c;
        bus.Go = 1'b1;
        @(posedge clk);
        #1;
        bus.Go = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output logic busy_at);
        seen = 1'b0;
        busy_at = 1'bx;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                seen = 1'b1;
                busy_at = bus.Busy;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({bus.Busy, bus.Done, bus.Draw} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got busy/done/draw=%b want 000", {bus.Busy, bus.Done, bus.Draw});
        end
        total++;
        if (bus.Pixel_Address !== 32'h0 || bus.Pixel_Color !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got addr=%h color=%h want 0", bus.Pixel_Address, bus.Pixel_Color);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_vertical;
        bit s;
        logic b;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        for (int y = 1; y <= 10; y++)
            for (int x = 0; x <= 5; x++) exp_q.push_back(pix(x, y, 16'hF00D));
        start(1'b0, 0, 1, 0, 10, 10, 16'hF00D);
        wait_done(s, b);
        total++;
        if (!s || b !== 1'b0 || pix_cnt != 60 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL vertical got done=%0d busy=%b pixels=%0d pulses=%0d left=%0d want 1 0 60 1 0",
                     s, b, pix_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_horizontal;
        bit s, got;
        logic b;
        int lat;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pix(10 + i, 100, 16'hA5A5));
        start(1'b0, 10, 100, 13, 100, 1, 16'hA5A5);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.Draw) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        total++;
        if (!got || lat != 3) begin
            bad++;
            $display("FAIL first_draw_latency got seen=%0d edges=%0d want 1 3", got, lat);
        end
        wait_done(s, b);
        total++;
        if (!s || b !== 1'b0 || pix_cnt != 4 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL horizontal got done=%0d busy=%b pixels=%0d pulses=%0d left=%0d want 1 0 4 1 0",
                     s, b, pix_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reversed;
        bit s;
        logic b;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pix(13 - i, 100, 16'h0C0C));
        start(1'b0, 13, 100, 10, 100, 0, 16'h0C0C);
        wait_done(s, b);
        total++;
        if (!s || b !== 1'b0 || pix_cnt != 4 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reversed got done=%0d busy=%b pixels=%0d pulses=%0d left=%0d want 1 0 4 1 0",
                     s, b, pix_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_diagonal;
        bit s;
        logic b;
        int xs[6];
        int ys[6];
        xs = '{0, 1, 2, 3, 4, 5};
        ys = '{0, 0, 1, 1, 2, 2};
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pix(i, i, 16'h1111));
        start(1'b0, 0, 0, 3, 3, 1, 16'h1111);
        wait_done(s, b);
        total++;
        if (!s || pix_cnt != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL diag45 got done=%0d pixels=%0d left=%0d want 1 4 0", s, pix_cnt, exp_q.size());
        end
        pix_cnt = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(pix(xs[i], ys[i], 16'h2222));
        start(1'b0, 0, 0, 5, 2, 1, 16'h2222);
        wait_done(s, b);
        total++;
        if (!s || pix_cnt != 6 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL shallow got done=%0d pixels=%0d left=%0d want 1 6 0", s, pix_cnt, exp_q.size());
        end
        pix_cnt = 0;
        for (int i = 4; i <= 6; i++) exp_q.push_back(pix(5, i, 16'h3333));
        start(1'b0, 5, 5, 5, 5, 3, 16'h3333);
        wait_done(s, b);
        total++;
        if (!s || pix_cnt != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_point got done=%0d pixels=%0d left=%0d want 1 3 0", s, pix_cnt, exp_q.size());
        end
    endtask

    task automatic test_rect;
        bit s;
        logic b;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        exp_q.push_back(pix(5, 7, 16'h4444));
        exp_q.push_back(pix(6, 7, 16'h4444));
        exp_q.push_back(pix(5, 8, 16'h4444));
        exp_q.push_back(pix(6, 8, 16'h4444));
        start(1'b1, 6, 8, 5, 7, 7, 16'h4444);
        wait_done(s, b);
        total++;
        if (!s || b !== 1'b0 || pix_cnt != 4 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rect got done=%0d busy=%b pixels=%0d pulses=%0d left=%0d want 1 0 4 1 0",
                     s, b, pix_cnt, done_cnt, exp_q.size());
        end
        pix_cnt = 0;
        done_cnt = 0;
        start(1'b1, 330, 0, 335, 0, 1, 16'h5555);
        wait_done(s, b);
        total++;
        if (!s || pix_cnt != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL rect_clipped got done=%0d pixels=%0d pulses=%0d want 1 0 1", s, pix_cnt, done_cnt);
        end
    endtask

    task automatic test_hold_and_go;
        bit s, got;
        logic b;
        int unstable;
        logic [47:0] first;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b0;
        first = pix(10, 100, 16'h1234);
        exp_q.push_back(first);
        exp_q.push_back(pix(11, 100, 16'h1234));
        start(1'b0, 10, 100, 11, 100, 1, 16'h1234);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.Draw;
        end
        bus.X0 = 9'd0;
        bus.Color = 16'hFFFF;
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.Go = (i >= 10 && i < 13);
            if (bus.Draw !== 1'b1 || {bus.Pixel_Color, bus.Pixel_Address} !== first) unstable++;
        end
        bus.Go = 1'b0;
        total++;
        if (!got || unstable != 0) begin
            bad++;
            $display("FAIL hold_stable got draw_seen=%0d unstable_cycles=%0d want 1 0", got, unstable);
        end
        auto_ack = 1'b1;
        wait_done(s, b);
        repeat (10) @(negedge clk);
        total++;
        if (!s || pix_cnt != 2 || done_cnt != 1 || exp_q.size() != 0 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL go_while_busy got done=%0d pixels=%0d pulses=%0d left=%0d busy=%b want 1 2 1 0 0",
                     s, pix_cnt, done_cnt, exp_q.size(), bus.Busy);
        end
    endtask

    task automatic test_reset_mid;
        bit s;
        logic b;
        exp_q.delete();
        pix_cnt = 0;
        done_cnt = 0;
        auto_ack = 1'b1;
        for (int y = 1; y <= 10; y++)
            for (int x = 0; x <= 5; x++) exp_q.push_back(pix(x, y, 16'h7777));
        start(1'b0, 0, 1, 0, 10, 10, 16'h7777);
        for (int i = 0; i < 500 && pix_cnt < 5; i++) @(negedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        total++;
        if ({bus.Busy, bus.Done, bus.Draw} !== 3'b000 || bus.Pixel_Address !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got busy/done/draw=%b addr=%h want 000 0",
                     {bus.Busy, bus.Done, bus.Draw}, bus.Pixel_Address);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        pix_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(pix(10 + i, 100, 16'h8888));
        start(1'b0, 10, 100, 13, 100, 1, 16'h8888);
        wait_done(s, b);
        total++;
        if (!s || b !== 1'b0 || pix_cnt != 4 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL after_reset got done=%0d busy=%b pixels=%0d pulses=%0d left=%0d want 1 0 4 1 0",
                     s, b, pix_cnt, done_cnt, exp_q.size());
        end
    endtask

    initial begin
        bus.Go = 1'b0;
        bus.Mode = 1'b0;
        bus.X0 = '0;
        bus.X1 = '0;
        bus.Y0 = '0;
        bus.Y1 = '0;
        bus.Thickness = '0;
        bus.Color = '0;
        test_reset();
        test_vertical();
        test_horizontal();
        test_reversed();
        test_diagonal();
        test_rect();
        test_hold_and_go();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
